// File: rtl/cdc_pkg.sv
// rtl/cdc_pkg.sv - shared constants and state type for the request/acknowledge CDC pair
package cdc_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    // Defaults shared with the destination-side receiver so both ends agree.
    localparam int DEF_BUS_WIDTH  = 8;
    localparam int DEF_NUM_STAGES = 2;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_REQ  = S_REQ,
        ST_DROP = S_DROP
    } state_e;

endpackage

// File: rtl/cdc_sync_flops.sv
// rtl/cdc_sync_flops.sv - multi-flop synchronizer for level signals crossing into CLK
module cdc_sync_flops #(
    parameter int WIDTH      = 1,
    parameter int NUM_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] ASYNC,
    output logic [WIDTH-1:0] SYNC
);

    logic [NUM_STAGES-1:0][WIDTH-1:0] sync_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[NUM_STAGES-2:0], ASYNC};
        end
    end

    assign SYNC = sync_q[NUM_STAGES-1];

endmodule

// File: rtl/cdc_hs_sender.sv
// rtl/cdc_hs_sender.sv - source end of a 4-phase req/ack crossing with ack timeout
module cdc_hs_sender
    import cdc_pkg::*;
#(
    parameter int BUS_WIDTH      = DEF_BUS_WIDTH,
    parameter int NUM_STAGES     = DEF_NUM_STAGES,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] IN_DATA,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    output logic [BUS_WIDTH-1:0] TX_DATA,
    output logic                 TX_REQ,
    input  logic                 ACK_ASYNC,
    output logic                 BUSY,
    output logic                 ERR
);

    localparam logic [CNT_WIDTH-1:0] TMO_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_e                 state_q;
    logic                   tx_req_q;
    logic [BUS_WIDTH-1:0]   tx_data_q;
    logic                   err_q;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic [CNT_WIDTH-1:0]   cnt_d;
    logic                   ack_s;
    logic                   timeout_hit;

    cdc_sync_flops #(
        .WIDTH      (1),
        .NUM_STAGES (NUM_STAGES)
    ) u_ack_sync (
        .CLK   (CLK),
        .RST   (RST),
        .ASYNC (ACK_ASYNC),
        .SYNC  (ack_s)
    );

    // Saturating increment: a disabled timeout must not wrap the counter.
    assign cnt_d       = (cnt_q == '1) ? cnt_q : cnt_q + CNT_WIDTH'(1);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TMO_LAST);

    assign IN_READY = (state_q == ST_IDLE) & ~ack_s & ~RST;
    assign BUSY     = (state_q != ST_IDLE);
    assign TX_REQ   = tx_req_q;
    assign TX_DATA  = tx_data_q;
    assign ERR      = err_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            tx_req_q  <= 1'b0;
            tx_data_q <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (IN_VALID && IN_READY) begin
                        tx_data_q <= IN_DATA;
                        tx_req_q  <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // A synchronized ack on the timeout edge takes priority over ERR.
                    if (ack_s) begin
                        tx_req_q <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= ST_DROP;
                    end else if (timeout_hit) begin
                        err_q    <= 1'b1;
                        tx_req_q <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= ST_DROP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_DROP: begin
                    if (!ack_s) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else if (timeout_hit) begin
                        err_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    tx_req_q <= 1'b0;
                    cnt_q    <= '0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/cdc_hs_sender.md
Name: cdc_hs_sender

Overview:
Source-domain end of a 4-phase request/acknowledge clock-domain crossing. Accepts a word on a valid/ready interface, holds it stable on TX_DATA, and raises TX_REQ toward the destination domain. The destination samples TX_REQ through its multi-flop bit synchronizer and returns ACK_ASYNC. This block synchronizes ACK_ASYNC back, completes the handshake, and flags a timeout if the far side never answers.

Parameters:
BUS_WIDTH, 8, width of the transferred word
NUM_STAGES, 2, flop count of the internal ACK synchronizer (legal range 2..8)
TIMEOUT_CYCLES, 1024, cycles allowed in REQ or DROP before ERR; 0 disables the timeout
CNT_WIDTH, 16, timeout counter width (must satisfy TIMEOUT_CYCLES < 2**CNT_WIDTH)

Ports:
CLK  input  1  source-domain clock
RST  input  1  reset; one clock, reset asynchronous and active-high
IN_DATA  input  BUS_WIDTH  word to send
IN_VALID  input  1  IN_DATA is valid
IN_READY  output  1  block can accept a word
TX_DATA  output  BUS_WIDTH  registered word, stable for as long as TX_REQ=1
TX_REQ  output  1  registered request level toward the destination domain
ACK_ASYNC  input  1  acknowledge from the destination domain, asynchronous to CLK
BUSY  output  1  handshake in progress (state != IDLE)
ERR  output  1  one-cycle pulse on timeout

Behaviour:
- Reset (asynchronous, active-high):
  - TX_REQ=0, TX_DATA=0, ERR=0, BUSY=0.
  - Synchronizer flops are 0. State is IDLE and the counter is 0.
  - IN_READY=0 while RST=1.
- ack_s is the output of the NUM_STAGES-flop chain on ACK_ASYNC. A change on ACK_ASYNC is visible on ack_s after NUM_STAGES rising edges.
- IN_READY = (state==IDLE) & ~ack_s & ~RST. It is combinational and has no dependence on IN_VALID.
- FSM states are IDLE, REQ and DROP:
  - IDLE: on IN_VALID&IN_READY at an edge, capture TX_DATA<=IN_DATA, set TX_REQ<=1, clear the counter and go to REQ. Otherwise hold.
  - REQ: TX_REQ=1 and TX_DATA frozen.
    - If ack_s=1: TX_REQ<=0, clear the counter, go to DROP.
    - Else if TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1: ERR<=1 for one cycle, TX_REQ<=0, clear the counter, go to DROP.
    - Else increment the counter.
  - DROP: TX_REQ=0.
    - If ack_s=0: go to IDLE.
    - A timeout here also pulses ERR, then the block goes to IDLE.
    - TX_DATA holds its last value.
- Latency:
  - Acceptance edge to TX_REQ high is 1 edge.
  - ACK_ASYNC rise to TX_REQ low is NUM_STAGES+1 edges.
  - ACK_ASYNC fall to IN_READY high is NUM_STAGES+1 edges.
- Simultaneous events:
  - ack_s=1 on the same edge as the timeout: the ack wins and ERR stays 0.
  - IN_VALID while not ready is ignored. No buffering and no loss of the held word.
- Spurious ack_s=1 in IDLE keeps IN_READY=0 until ack_s falls. No transfer starts.
- Counter saturates and never wraps. It is cleared on every state transition.
- RST mid-handshake forces TX_REQ low immediately. The destination sees the request withdrawn, which is a legal 4-phase abort.

Decomposition:
- Shared package cdc_pkg holds:
  - state encoding constants S_IDLE=2'd0, S_REQ=2'd1, S_DROP=2'd2
  - default BUS_WIDTH and NUM_STAGES constants shared with the destination-side receiver
- Sub-module cdc_sync_flops (params WIDTH, NUM_STAGES; ports CLK, RST, ASYNC, SYNC) is the multi-flop synchronizer used for ACK_ASYNC. It resets to 0 asynchronously on RST high.

Test Plan:
1. Basic transfer: RST pulse, then IN_DATA=8'hA5 with IN_VALID=1 for one cycle. Required: TX_REQ=1 and TX_DATA=8'hA5 after 1 edge. Raise ACK_ASYNC: TX_REQ=0 exactly 3 edges later (NUM_STAGES=2). Drop ACK_ASYNC: IN_READY=1 3 edges later. ERR stays 0.
2. Backpressure: while BUSY, drive IN_VALID=1 with IN_DATA=8'h3C. Required: IN_READY=0 and TX_DATA stays 8'hA5. Once back in IDLE, 8'h3C is accepted and sent.
3. Timeout: TIMEOUT_CYCLES=16, ACK_ASYNC held at 0. Required: ERR high for exactly one cycle 16 edges after acceptance, TX_REQ drops on that edge, IN_READY=1 on the next edge.
4. Ack/timeout race: ack timed so ack_s rises on the timeout edge. Required: ERR=0, state goes to DROP, TX_REQ=0.
5. Reset mid-handshake: assert RST while in REQ with TX_DATA=8'hFF. Required: TX_REQ=0 and TX_DATA=0 immediately (asynchronous, not at the next edge), BUSY=0, IN_READY=1 after RST falls.
6. Back-to-back: 4 words 8'h01..8'h04 with an ack responder modeled at 2 synchronizer stages. Required: TX_DATA takes each value in order, one TX_REQ rise per word, no ERR.
